pe_mac_mb: RTL
==============

# pe_mac_mb

Next-generation processing element for the GEMM systolic array. It holds a parametrised multi-entry weight bank, selects one of NUM_ACT_CH activation channels per cycle and runs a pipelined signed integer MAC. It forwards activations horizontally and accumulations vertically with valid qualifiers. An optional output-stationary accumulation mode can be compiled in.

## Interface
Parameters:
- NUM_ACT_CH, 4, number of activation input channels
- ACT_WIDTH, 8, activation width, signed
- NUM_WT_ENT, 4, weight bank entries (≥2)
- WT_WIDTH, 8, weight width, signed
- ACC_WIDTH, 32, accumulation width (≥ ACT_WIDTH+WT_WIDTH)
- MULT_LATENCY, 1, multiplier pipeline stages (≥1)
- ADDER_LATENCY, 1, adder pipeline stages (≥1)
- MAC_LATENCY, MULT_LATENCY+ADDER_LATENCY+1, derived; input-to-acc_data_out cycles

Ports:
- clk  in  1  clock; single clock domain
- reset_n  in  1  synchronous, active-low reset
- pe_en  in  1  global advance; 0 freezes all state
- act_valid_in  in  1  activation valid
- act_ch_sel  in  $clog2(NUM_ACT_CH)  binary channel index
- act_data_in  in  NUM_ACT_CH×ACT_WIDTH  activation channels
- act_valid_out  out  1  registered act_valid_in to PE (i,j+1)
- act_ch_sel_out  out  $clog2(NUM_ACT_CH)  registered act_ch_sel
- act_data_out  out  NUM_ACT_CH×ACT_WIDTH  registered act_data_in
- wt_load_en  in  1  column-broadcast weight shift enable
- wt_load_idx  in  $clog2(NUM_WT_ENT)  bank entry being loaded
- wt_data_in  in  WT_WIDTH  weight from PE (i-1,j) or column head
- wt_data_out  out  WT_WIDTH  combinational bank[wt_load_idx] to PE (i+1,j)
- wt_comp_idx  in  $clog2(NUM_WT_ENT)  entry used for compute
- wt_comp_idx_out  out  $clog2(NUM_WT_ENT)  wt_comp_idx delayed MAC_LATENCY
- acc_data_in  in  ACC_WIDTH  partial sum from PE (i-1,j)
- acc_valid_in  in  1  partial sum valid
- acc_data_out  out  ACC_WIDTH  partial sum to PE (i+1,j)
- acc_valid_out  out  1  acc_data_out valid
- os_mode  in  1  output-stationary select (only with PE_OS_MODE_EN)
- os_drain  in  1  drain local accumulator (only with PE_OS_MODE_EN)

## Operation
- Stage 0, when pe_en=1: register act_data_in, act_valid_in, act_ch_sel, acc_data_in, acc_valid_in, wt_comp_idx, os_drain. Mux selection uses the registered act_ch_sel.
- Selected activation × bank[registered wt_comp_idx] is a signed full-width product, sign-extended to ACC_WIDTH.
- Invalid activation contributes 0.
- Weight-stationary: acc_data_out = acc_data_in + product, modulo 2^ACC_WIDTH, no saturation.
- acc_valid_out = act_valid_in | acc_valid_in, pipelined.
- Weight shift: when wt_load_en & pe_en, bank[wt_load_idx] <= wt_data_in. wt_data_out shows the old bank[wt_load_idx].
  - Over N consecutive loads, a column of N PEs acts as a shift register; the first pushed weight lands in the bottom PE.
- Load and compute may target the same entry in the same cycle: compute uses the pre-write value.
- wt_comp_idx_out is delayed MAC_LATENCY so that the row-(i+1) compute selection aligns with its arriving partial sum.

## Timing
- Input sampled at edge t produces acc_data_out/acc_valid_out after edge t+MAC_LATENCY-1, counting only cycles with pe_en=1.
- act_*_out latency: 1 cycle.
- wt_data_out: combinational from the bank and wt_load_idx.
- pe_en=0: every register holds, including the bank, pipeline and local accumulator. Outputs hold.
- reset_n=0 at an edge: all pipeline, bank and accumulator registers clear to 0. This overrides pe_en and any load.
- Reset values: act_valid_out=0, act_ch_sel_out=0, act_data_out=0, wt_comp_idx_out=0, acc_data_out=0, acc_valid_out=0. wt_data_out=0, since the bank is cleared.
- Reset mid-operation discards in-flight data. The first valid output follows a fresh input by MAC_LATENCY.

## Configuration
- Macro: PE_OS_MODE_EN.
- Defined:
  - os_mode/os_drain ports and an ACC_WIDTH local accumulator exist.
  - With os_mode=1, the product adds into the local accumulator.
  - acc_data_out/acc_valid_out pass the pipelined acc_data_in/acc_valid_in through unchanged.
  - At the final stage, a pipelined drain outputs local+product (product 0 if invalid) with acc_valid_out=1. The local accumulator is cleared in the same cycle.
  - Drain overrides passthrough that cycle; a colliding upstream valid is dropped, and array control must space drains.
- Undefined: ports absent; weight-stationary only.

## Test plan
- Reset: hold reset_n=0 for 3 cycles with random inputs → all outputs 0. Bank reads 0 via wt_data_out.
- WS MAC with defaults: bank[2]=-3, wt_comp_idx=2, act_ch_sel=1, ch1=7, acc_data_in=100, valid=1 → acc_data_out=79, acc_valid_out=1 exactly 3 cycles later.
- Column shift with 3 stacked PEs: idx=0, push 5, 6, 7 over 3 cycles → bank[0]=7, 6, 5 top to bottom.
- Same-entry load/compute collision: bank[1]=4, load 9 into entry 1 while computing act=2 on entry 1 → product 8. Next compute gives 18.
- pe_en=0 for 2 cycles mid-pipeline → outputs frozen; the result appears 2 cycles late with an unchanged value. Wrap case: acc_data_in=0x7FFFFFFF, product 1 → 0x80000000.
- With PE_OS_MODE_EN: os_mode=1, products 2, 3, 4, then drain with product 5 → acc_data_out=14, valid=1. The local accumulator is 0 afterwards.

Source files
------------

// File: rtl/pe_mac_mb_if.sv
// Bus bundle for pe_mac_mb: activation, weight-shift and partial-sum signals.
// PE_OS_MODE_EN adds the os_mode/os_drain controls.
interface pe_mac_mb_if #(
    parameter int unsigned NUM_ACT_CH = 4,
    parameter int unsigned ACT_WIDTH  = 8,
    parameter int unsigned NUM_WT_ENT = 4,
    parameter int unsigned WT_WIDTH   = 8,
    parameter int unsigned ACC_WIDTH  = 32
);
    localparam int unsigned SELW = $clog2(NUM_ACT_CH);
    localparam int unsigned IDXW = $clog2(NUM_WT_ENT);

    logic                             pe_en;
    logic                             act_valid_in;
    logic [SELW-1:0]                  act_ch_sel;
    logic [NUM_ACT_CH*ACT_WIDTH-1:0]  act_data_in;
    logic                             act_valid_out;
    logic [SELW-1:0]                  act_ch_sel_out;
    logic [NUM_ACT_CH*ACT_WIDTH-1:0]  act_data_out;
    logic                             wt_load_en;
    logic [IDXW-1:0]                  wt_load_idx;
    logic [WT_WIDTH-1:0]              wt_data_in;
    logic [WT_WIDTH-1:0]              wt_data_out;
    logic [IDXW-1:0]                  wt_comp_idx;
    logic [IDXW-1:0]                  wt_comp_idx_out;
    logic [ACC_WIDTH-1:0]             acc_data_in;
    logic                             acc_valid_in;
    logic [ACC_WIDTH-1:0]             acc_data_out;
    logic                             acc_valid_out;
`ifdef PE_OS_MODE_EN
    logic                             os_mode;
    logic                             os_drain;
`endif

    modport master (
        output pe_en, act_valid_in, act_ch_sel, act_data_in,
        output wt_load_en, wt_load_idx, wt_data_in, wt_comp_idx,
        output acc_data_in, acc_valid_in,
`ifdef PE_OS_MODE_EN
        output os_mode, os_drain,
`endif
        input  act_valid_out, act_ch_sel_out, act_data_out,
        input  wt_data_out, wt_comp_idx_out, acc_data_out, acc_valid_out
    );

    modport slave (
        input  pe_en, act_valid_in, act_ch_sel, act_data_in,
        input  wt_load_en, wt_load_idx, wt_data_in, wt_comp_idx,
        input  acc_data_in, acc_valid_in,
`ifdef PE_OS_MODE_EN
        input  os_mode, os_drain,
`endif
        output act_valid_out, act_ch_sel_out, act_data_out,
        output wt_data_out, wt_comp_idx_out, acc_data_out, acc_valid_out
    );
endinterface

// File: rtl/pe_mac_mb.sv
// Systolic GEMM processing element: multi-entry weight bank, channel-selected signed MAC pipeline.
// Define PE_OS_MODE_EN to add the output-stationary local accumulator and drain path.
module pe_mac_mb #(
    parameter int unsigned NUM_ACT_CH    = 4,
    parameter int unsigned ACT_WIDTH     = 8,
    parameter int unsigned NUM_WT_ENT    = 4,
    parameter int unsigned WT_WIDTH      = 8,
    parameter int unsigned ACC_WIDTH     = 32,
    parameter int unsigned MULT_LATENCY  = 1,
    parameter int unsigned ADDER_LATENCY = 1,
    parameter int unsigned MAC_LATENCY   = MULT_LATENCY + ADDER_LATENCY + 1
) (
    input logic        clk,
    input logic        reset_n,
    pe_mac_mb_if.slave bus
);
    localparam int unsigned SELW = $clog2(NUM_ACT_CH);
    localparam int unsigned IDXW = $clog2(NUM_WT_ENT);
    localparam int unsigned PW   = ACT_WIDTH + WT_WIDTH;

    typedef struct packed {
        logic [ACC_WIDTH-1:0] acc;
        logic                 acc_v;
        logic                 act_v;
`ifdef PE_OS_MODE_EN
        logic                 drain;
        logic                 osm;
`endif
    } side_t;

    logic [WT_WIDTH-1:0]             bank_q [NUM_WT_ENT];
    logic [NUM_ACT_CH*ACT_WIDTH-1:0] act_data_q;
    logic [SELW-1:0]                 act_sel_q;
    logic signed [WT_WIDTH-1:0]      wt_q;
    side_t                           s0_q, s0_d;
    logic [ACC_WIDTH-1:0]            mprod_q [MULT_LATENCY];
    side_t                           mside_q [MULT_LATENCY];
    logic [ACC_WIDTH-1:0]            aout_q  [ADDER_LATENCY];
    logic [ADDER_LATENCY-1:0]        avalid_q;
    logic [IDXW-1:0]                 cidx_q  [MAC_LATENCY];

    logic signed [ACT_WIDTH-1:0]     act_sel;
    logic signed [PW-1:0]            prod_full;
    logic signed [ACC_WIDTH-1:0]     prod_sx;
    logic [ACC_WIDTH-1:0]            prod_d;
    side_t                           add_side;
    logic [ACC_WIDTH-1:0]            add_prod;
    logic [ACC_WIDTH-1:0]            sum_d;
    logic                            sumv_d;
`ifdef PE_OS_MODE_EN
    logic [ACC_WIDTH-1:0]            lacc_q, lacc_d;
`endif

    always_comb begin
        s0_d       = '0;
        s0_d.acc   = bus.acc_data_in;
        s0_d.acc_v = bus.acc_valid_in;
        s0_d.act_v = bus.act_valid_in;
`ifdef PE_OS_MODE_EN
        s0_d.drain = bus.os_drain;
        s0_d.osm   = bus.os_mode;
`endif
    end

    // wt_q snapshots the bank at input time, so a same-cycle load never disturbs this compute.
    always_comb begin
        act_sel = '0;
        for (int unsigned i = 0; i < NUM_ACT_CH; i++) begin
            if (act_sel_q == SELW'(i)) begin
                act_sel = act_data_q[i*ACT_WIDTH +: ACT_WIDTH];
            end
        end
        prod_full = PW'(act_sel) * PW'(wt_q);
        prod_sx   = ACC_WIDTH'(prod_full);
        prod_d    = s0_q.act_v ? prod_sx : '0;
    end

    always_comb begin
        add_side = mside_q[MULT_LATENCY-1];
        add_prod = mprod_q[MULT_LATENCY-1];
        sum_d    = add_side.acc + add_prod;
        sumv_d   = add_side.act_v | add_side.acc_v;
`ifdef PE_OS_MODE_EN
        lacc_d   = lacc_q;
        // Drain wins over passthrough; a coincident upstream partial sum is dropped.
        if (add_side.drain) begin
            sum_d  = lacc_q + add_prod;
            sumv_d = 1'b1;
            lacc_d = '0;
        end else if (add_side.osm) begin
            lacc_d = lacc_q + add_prod;
            sum_d  = add_side.acc;
            sumv_d = add_side.acc_v;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < NUM_WT_ENT; k++) bank_q[k] <= '0;
            act_data_q <= '0;
            act_sel_q  <= '0;
            wt_q       <= '0;
            s0_q       <= '0;
            for (int unsigned k = 0; k < MULT_LATENCY; k++) begin
                mprod_q[k] <= '0;
                mside_q[k] <= '0;
            end
            for (int unsigned k = 0; k < ADDER_LATENCY; k++) aout_q[k] <= '0;
            avalid_q <= '0;
            for (int unsigned k = 0; k < MAC_LATENCY; k++) cidx_q[k] <= '0;
`ifdef PE_OS_MODE_EN
            lacc_q <= '0;
`endif
        end else if (bus.pe_en) begin
            if (bus.wt_load_en) bank_q[bus.wt_load_idx] <= bus.wt_data_in;
            act_data_q <= bus.act_data_in;
            act_sel_q  <= bus.act_ch_sel;
            wt_q       <= bank_q[bus.wt_comp_idx];
            s0_q       <= s0_d;
            mprod_q[0] <= prod_d;
            mside_q[0] <= s0_q;
            for (int unsigned k = 1; k < MULT_LATENCY; k++) begin
                mprod_q[k] <= mprod_q[k-1];
                mside_q[k] <= mside_q[k-1];
            end
            aout_q[0]   <= sum_d;
            avalid_q[0] <= sumv_d;
            for (int unsigned k = 1; k < ADDER_LATENCY; k++) begin
                aout_q[k]   <= aout_q[k-1];
                avalid_q[k] <= avalid_q[k-1];
            end
            cidx_q[0] <= bus.wt_comp_idx;
            for (int unsigned k = 1; k < MAC_LATENCY; k++) cidx_q[k] <= cidx_q[k-1];
`ifdef PE_OS_MODE_EN
            lacc_q <= lacc_d;
`endif
        end
    end

    assign bus.act_valid_out   = s0_q.act_v;
    assign bus.act_ch_sel_out  = act_sel_q;
    assign bus.act_data_out    = act_data_q;
    assign bus.wt_data_out     = bank_q[bus.wt_load_idx];
    assign bus.wt_comp_idx_out = cidx_q[MAC_LATENCY-1];
    assign bus.acc_data_out    = aout_q[ADDER_LATENCY-1];
    assign bus.acc_valid_out   = avalid_q[ADDER_LATENCY-1];
endmodule
